// File: rtl/ccg_bist_pkg.sv
// Shared types and step functions for the ccg BIST harness.
// Step functions work on 64-bit containers; callers pass the active width.
package ccg_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } bist_state_t;

  localparam logic [26:0] DEF_LFSR_POLY = 27'h4000027;
  localparam logic [28:0] DEF_MISR_POLY = 29'h10000005;

  // Galois shift: drop the MSB, fold it back through the taps.
  function automatic logic [63:0] lfsr_step(input logic [63:0] state,
                                            input logic [63:0] poly,
                                            input int          width);
    logic [63:0] mask;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return ((state << 1) & mask) ^ (state[6'(width - 1)] ? poly : 64'd0);
  endfunction

  function automatic logic [63:0] misr_step(input logic [63:0] state,
                                            input logic [63:0] poly,
                                            input logic [63:0] data,
                                            input int          width);
    return lfsr_step(state, poly, width) ^ data;
  endfunction

endpackage

// File: rtl/ccg_lfsr_gen.sv
// Galois LFSR pattern source: loads a seed (zero replaced by 1) and steps on enable.
module ccg_lfsr_gen
  import ccg_bist_pkg::*;
#(
  parameter int           W    = 27,
  parameter logic [W-1:0] POLY = DEF_LFSR_POLY
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] seed,
  output logic [W-1:0] state
);

  logic [W-1:0] seed_eff;

  // An all-zero Galois LFSR never leaves zero.
  assign seed_eff = (seed == '0) ? W'(1) : seed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= '0;
    end else if (load) begin
      state <= seed_eff;
    end else if (step) begin
      state <= W'(lfsr_step(64'(state), 64'(POLY), W));
    end
  end

endmodule

// File: rtl/ccg_bist_harness.sv
// BIST wrapper: LFSR patterns into a DUT cone, MISR compaction, signature compare.
// Optional macro CCG_BIST_XMASK_EN adds an xmask port that zeroes selected outputs before capture.
//   state | meaning
//   IDLE  | waiting for start; last signature/pass held
//   RUN   | one pattern per cycle on dut_in
//   DRAIN | dut_in held while the DUT pipeline empties
//   DONE  | one-cycle done pulse with pass
module ccg_bist_harness
  import ccg_bist_pkg::*;
#(
  parameter int               N_IN      = 27,
  parameter int               N_OUT     = 29,
  parameter logic [N_IN-1:0]  LFSR_POLY = DEF_LFSR_POLY,
  parameter logic [N_OUT-1:0] MISR_POLY = DEF_MISR_POLY,
  parameter int               CNT_W     = 16,
  parameter int               DUT_LAT   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N_IN-1:0]  seed,
  input  logic [CNT_W-1:0] n_pat,
  input  logic [N_OUT-1:0] exp_sig,
  output logic [N_IN-1:0]  dut_in,
  input  logic [N_OUT-1:0] dut_out,
`ifdef CCG_BIST_XMASK_EN
  input  logic [N_OUT-1:0] xmask,
`endif
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_OUT-1:0] signature
);

  bist_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last_idx;
  logic [N_OUT-1:0] exp_r;
  logic [N_OUT-1:0] misr;
  logic [N_OUT-1:0] cap_data;
  logic [N_OUT-1:0] misr_upd;
  logic             cap_valid;
  logic             drain_last;
  logic             lfsr_load;
  logic             lfsr_adv;

  assign lfsr_load = (state == IDLE) && start;
  // The LFSR stops on the final pattern so dut_in holds through DRAIN.
  assign lfsr_adv  = (state == RUN) && (cnt != last_idx);

  ccg_lfsr_gen #(
    .W    (N_IN),
    .POLY (LFSR_POLY)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .step  (lfsr_adv),
    .seed  (seed),
    .state (dut_in)
  );

`ifdef CCG_BIST_XMASK_EN
  logic [N_OUT-1:0] xmask_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xmask_r <= '0;
    end else if (lfsr_load) begin
      xmask_r <= xmask;
    end
  end

  assign cap_data = dut_out & ~xmask_r;
`else
  assign cap_data = dut_out;
`endif

  // Valid pipe marks which cycle carries the response to each pattern.
  generate
    if (DUT_LAT > 0) begin : g_vpipe
      logic [DUT_LAT-1:0] vpipe;
      logic [DUT_LAT-1:0] vpipe_sh;

      assign vpipe_sh = (vpipe << 1) | DUT_LAT'(state == RUN);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vpipe <= '0;
        end else begin
          vpipe <= vpipe_sh;
        end
      end

      assign cap_valid  = vpipe[DUT_LAT-1];
      assign drain_last = (vpipe_sh == '0);
    end else begin : g_no_vpipe
      assign cap_valid  = (state == RUN);
      assign drain_last = 1'b1;
    end
  endgenerate

  assign misr_upd  = cap_valid
                   ? N_OUT'(misr_step(64'(misr), 64'(MISR_POLY), 64'(cap_data), N_OUT))
                   : misr;
  assign signature = misr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      last_idx <= '0;
      exp_r    <= '0;
      misr     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
    end else begin
      done <= 1'b0;
      misr <= misr_upd;
      unique case (state)
        IDLE: begin
          if (start) begin
            last_idx <= (n_pat == '0) ? '0 : n_pat - CNT_W'(1);
            exp_r    <= exp_sig;
            misr     <= '0;
            cnt      <= '0;
            pass     <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == last_idx) begin
            if (DUT_LAT == 0) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (misr_upd == exp_r);
              state <= DONE;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (misr_upd == exp_r);
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
